// File: rtl/mem_access_ctrl_if.sv
// Data port, auxiliary port and mem_main connections of the memory access controller.
// The master side holds the requesters and the memory; the controller uses the slave side.
interface mem_access_ctrl_if;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_ack;

  logic        a_req;
  logic        a_we;
  logic [15:0] a_addr;
  logic [15:0] a_wdata;
  logic [15:0] a_rdata;
  logic        a_ack;

  logic [15:0] mem_address;
  logic        mem_write_en;
  logic [15:0] mem_write_data;
  logic [15:0] mem_data;

  modport master (
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_ack,
    output a_req, a_we, a_addr, a_wdata,
    input  a_rdata, a_ack,
    input  mem_address, mem_write_en, mem_write_data,
    output mem_data
  );

  modport slave (
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_ack,
    input  a_req, a_we, a_addr, a_wdata,
    output a_rdata, a_ack,
    output mem_address, mem_write_en, mem_write_data,
    input  mem_data
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Round-robin arbiter/sequencer sharing mem_main between the data port and the aux port.
// Latency: ack WAIT_CYCLES+1 cycles after the grant cycle; stall holds the pipeline while d_req waits.
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt_sys,
  mem_access_ctrl_if.slave bus,
  output logic             stall,
  output logic             busy
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);
  localparam logic       PORT_D   = 1'b0;
  localparam logic       PORT_A   = 1'b1;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        grant_q;
  logic        last_grant_q;
  logic        we_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] d_rdata_q;
  logic [15:0] a_rdata_q;
  logic        pick_a;
  logic        start;
  logic        d_ack;
  logic        a_ack;
  logic        mem_write_en;

  always_comb begin
    state_d      = state_q;
    start        = 1'b0;
    busy         = 1'b0;
    d_ack        = 1'b0;
    a_ack        = 1'b0;
    mem_write_en = 1'b0;
    // Aux wins when alone, or on contention when data was granted last.
    pick_a       = bus.a_req & (~bus.d_req | (last_grant_q == PORT_D));
    case (state_q)
      IDLE: begin
        if (!halt_sys && (bus.d_req || bus.a_req)) begin
          start   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        busy         = 1'b1;
        mem_write_en = we_q && (cnt_q == CNT_INIT);
        if (cnt_q == 4'd0) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        d_ack   = (grant_q == PORT_D);
        a_ack   = (grant_q == PORT_A);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      grant_q      <= PORT_A;
      last_grant_q <= PORT_A;
      we_q         <= 1'b0;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
      d_rdata_q    <= 16'h0000;
      a_rdata_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (start) begin
        grant_q <= pick_a;
        we_q    <= pick_a ? bus.a_we    : bus.d_we;
        addr_q  <= pick_a ? bus.a_addr  : bus.d_addr;
        wdata_q <= pick_a ? bus.a_wdata : bus.d_wdata;
        cnt_q   <= CNT_INIT;
      end
      if (state_q == ACCESS) begin
        if (cnt_q == 4'd0) begin
          // Read data is taken on the edge that leaves ACCESS so rdata is valid with ack.
          if (!we_q) begin
            if (grant_q == PORT_A) a_rdata_q <= bus.mem_data;
            else                   d_rdata_q <= bus.mem_data;
          end
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
      end
      if (state_q == DONE) last_grant_q <= grant_q;
    end
  end

  assign bus.d_rdata        = d_rdata_q;
  assign bus.a_rdata        = a_rdata_q;
  assign bus.d_ack          = d_ack;
  assign bus.a_ack          = a_ack;
  assign bus.mem_address    = addr_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.mem_write_en   = mem_write_en;
  assign stall              = bus.d_req & ~d_ack;
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Two-port arbiter and sequencer for the single-port main memory (`mem_main`). It shares the memory between the stage-three load/store path (data port) and an auxiliary port used by the program loader and debug reads/writes. It runs a fixed-latency access state machine, applies round-robin arbitration and drives a pipeline stall while a data-port access is outstanding. It sits between stage three and `mem_main` and takes over the memory's address, write-enable and write-data connections.

## Interface
- `WAIT_CYCLES`, default 1: memory read latency in cycles; legal range 1..15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous reset, active high.
- `halt_sys`  in  1  when high, no new grant is issued; an access already in flight completes.
- `d_req`  in  1  data-port request; held high until `d_ack`.
- `d_we`  in  1  data-port write (1) or read (0).
- `d_addr`  in  16  data-port address.
- `d_wdata`  in  16  data-port write data.
- `d_rdata`  out  16  data-port read data, registered.
- `d_ack`  out  1  one-cycle completion pulse for the data port.
- `a_req`, `a_we`, `a_addr[15:0]`, `a_wdata[15:0]`  in  auxiliary-port equivalents of the data-port inputs.
- `a_rdata`  out  16  auxiliary-port read data, registered.
- `a_ack`  out  1  one-cycle completion pulse for the auxiliary port.
- `stall`  out  1  combinational `d_req & ~d_ack`; freezes stages one through three.
- `mem_address`  out  16  address to `mem_main`.
- `mem_write_en`  out  1  write strobe to `mem_main`.
- `mem_write_data`  out  16  write data to `mem_main`.
- `mem_data`  in  16  read data from `mem_main`; valid `WAIT_CYCLES` cycles after `mem_address` is stable.
- `busy`  out  1  high in the ACCESS and DONE states.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE, with `halt_sys` low and at least one request pending:
  - Grant the winning port.
  - Latch its `we`, address and write data into internal registers.
  - Load the wait counter with `WAIT_CYCLES-1`.
  - Go to ACCESS.
- Arbitration, single request: that port wins.
- Arbitration, both requests: the port not granted last wins.
  - `last_grant` resets to aux, so the data port wins the first contention after reset.
- ACCESS:
  - `mem_address` and `mem_write_data` are driven from the latched registers.
  - For writes, `mem_write_en` is high only in the first ACCESS cycle.
  - The counter decrements each cycle; at 0, the state goes to DONE.
  - On that same edge, for reads, `mem_data` is captured into the granted port's `rdata`.
- DONE:
  - The granted port's `ack` is high for exactly one cycle.
  - No arbitration happens in DONE; the state returns to IDLE.
  - `last_grant` is updated.
- Requests dropped mid-transaction are ignored; the transaction completes and still acks.
- `rdata` of each port holds its value until that port's next read completes. Writes leave `rdata` unchanged.
- Outside ACCESS: `mem_write_en` is 0, and `mem_address`/`mem_write_data` keep their last latched values.
- `halt_sys` rising during ACCESS or DONE does not abort the transaction. Arbitration resumes on the first IDLE cycle with `halt_sys` low.

## Timing
- Reset values:
  - state IDLE, counter 0, `last_grant` aux.
  - `d_rdata`, `a_rdata`, `mem_address`, `mem_write_data` all 0x0000.
  - `d_ack`, `a_ack`, `mem_write_en`, `busy` all 0.
  - `stall` follows `d_req`.
- `rst` takes priority in every state. An access in flight is abandoned with no ack. A write already strobed is not rolled back.
- Request sampled high at the end of IDLE cycle N:
  - ACCESS runs for cycles N+1 .. N+WAIT_CYCLES.
  - `ack` is high in cycle N+WAIT_CYCLES+1, with `rdata` valid in that same cycle.
  - IDLE is reached in cycle N+WAIT_CYCLES+2.
- Throughput: one access per WAIT_CYCLES+2 cycles.
- A request still high in the IDLE cycle after its ack is treated as a new request.
- `stall` has zero latency and drops in the `d_ack` cycle, so stage three advances on that edge.

## Test plan
- Single data read, WAIT_CYCLES=1, `mem[0x0010]=0xBEEF`, `d_req` high at cycle 0:
  - `mem_address=0x0010` in cycle 1.
  - `d_ack` high and `d_rdata=0xBEEF` in cycle 2.
  - `stall` high in cycles 0-1, low in cycle 2.
- Data write of 0x1234 to 0x0020, followed by an aux read of 0x0020:
  - `mem_write_en` high for exactly one cycle.
  - `a_rdata=0x1234` at `a_ack`.
  - `d_rdata` unchanged.
- `d_req` and `a_req` both held high for four transactions after reset:
  - Grant order is data, aux, data, aux.
  - Each ack is spaced WAIT_CYCLES+2 cycles apart.
- `halt_sys` high for 5 cycles with `d_req` high in IDLE:
  - No grant, `busy`=0, `stall`=1.
  - Grant on the first cycle after `halt_sys` falls.
  - With WAIT_CYCLES=3, `halt_sys` raised mid-ACCESS: the access still acks at N+4.
- `rst` asserted in the second ACCESS cycle (WAIT_CYCLES=3):
  - No ack follows.
  - All outputs take their reset values on the next cycle.
  - A new request after reset completes normally.
- `d_req` dropped after grant, WAIT_CYCLES=2:
  - `d_ack` still pulses at N+3.
  - The next IDLE cycle issues no new grant.
